// File: rtl/dma_desc_master_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dma_desc_master_arbiter_pkg
// Shared DMA descriptor-engine definitions: arbiter state encodings, the
// default read-outstanding limit, grant-history encodings and the
// fair-pick helper used when the arbiter is idle.
// ---------------------------------------------------------------------------
package dma_desc_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_RD = 2'd1,
        ST_GRANT_WR = 2'd2
    } arb_state_e;

    localparam int DEFAULT_MAX_OUTSTANDING = 4;

    // Which requester owned the bus for the most recent completed transfer.
    localparam logic LAST_FETCH = 1'b0;
    localparam logic LAST_UPD   = 1'b1;

    // Choose the next grant from IDLE. On a tie the requester that was not
    // served last wins, so back-to-back contention alternates.
    function automatic arb_state_e pick_grant(input logic fetch_elig,
                                              input logic upd_elig,
                                              input logic last_grant);
        arb_state_e nxt;
        if (fetch_elig && upd_elig) begin
            nxt = (last_grant == LAST_UPD) ? ST_GRANT_RD : ST_GRANT_WR;
        end else if (fetch_elig) begin
            nxt = ST_GRANT_RD;
        end else if (upd_elig) begin
            nxt = ST_GRANT_WR;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dma_desc_master_arbiter.sv
// ---------------------------------------------------------------------------
// dma_desc_master_arbiter
// Shares one Avalon-MM master between the descriptor-fetch reader
// (requester 0) and the descriptor-status update writer (requester 1).
// Every transfer passes through IDLE, so the bus carries at most one
// transfer per two cycles. Reads accepted by the slave but not yet answered
// are counted; fetches are held off once MAX_OUTSTANDING are in flight.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   fetch_rd_i/fetch_addr_i    fetch read request and byte address
//   fetch_wait_req_o           fetch stall (accepted when request=1 and this=0)
//   fetch_rd_data_o/_valid_o   read response, passed straight through
//   upd_wr_i/upd_addr_i/
//   upd_data_i/upd_be_i        update write request and payload
//   upd_wait_req_o             update stall
//   avm_*                      shared Avalon-MM master
// ---------------------------------------------------------------------------
module dma_desc_master_arbiter
    import dma_desc_master_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_rd_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_wait_req_o,
    output logic [31:0] fetch_rd_data_o,
    output logic        fetch_rd_valid_o,
    input  logic        upd_wr_i,
    input  logic [31:0] upd_addr_i,
    input  logic [31:0] upd_data_i,
    input  logic [3:0]  upd_be_i,
    output logic        upd_wait_req_o,
    output logic        avm_rd_o,
    output logic        avm_wr_o,
    output logic [31:0] avm_addr_o,
    output logic [31:0] avm_wdata_o,
    output logic [3:0]  avm_be_o,
    input  logic        avm_wait_req_i,
    input  logic [31:0] avm_rdata_i,
    input  logic        avm_rdvalid_i
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    arb_state_e  state_q;
    logic        last_grant_q;
    logic [3:0]  outstanding_q;
    logic [3:0]  outstanding_d;

    logic        fetch_elig_s;
    logic        accept_rd_s;
    logic        rsp_s;

    assign fetch_elig_s = fetch_rd_i && (outstanding_q < MAX_CNT);
    assign accept_rd_s  = (state_q == ST_GRANT_RD) && !avm_wait_req_i;
    // A response with nothing in flight is stale (e.g. issued before a
    // reset) and must not drive the counter below zero.
    assign rsp_s        = avm_rdvalid_i && (outstanding_q != 4'd0);

    // Arbiter FSM and grant history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_UPD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q      <= pick_grant(fetch_elig_s, upd_wr_i, last_grant_q);
                    last_grant_q <= last_grant_q;
                end
                ST_GRANT_RD: begin
                    if (!avm_wait_req_i) begin
                        state_q      <= ST_IDLE;
                        last_grant_q <= LAST_FETCH;
                    end else begin
                        state_q      <= ST_GRANT_RD;
                        last_grant_q <= last_grant_q;
                    end
                end
                ST_GRANT_WR: begin
                    if (!avm_wait_req_i) begin
                        state_q      <= ST_IDLE;
                        last_grant_q <= LAST_UPD;
                    end else begin
                        state_q      <= ST_GRANT_WR;
                        last_grant_q <= last_grant_q;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    last_grant_q <= LAST_UPD;
                end
            endcase
        end
    end

    // Next value of the outstanding-read counter; issue and return in the
    // same cycle cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept_rd_s && !rsp_s) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept_rd_s && rsp_s) begin
            outstanding_d = outstanding_q - 4'd1;
        end else begin
            outstanding_d = outstanding_q;
        end
    end

    // Outstanding-read counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= 4'd0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // Bus and stall decode from the granted state; payload is not
    // registered because requesters hold it stable until accepted.
    always_comb begin
        avm_rd_o         = 1'b0;
        avm_wr_o         = 1'b0;
        avm_addr_o       = 32'h0000_0000;
        avm_wdata_o      = 32'h0000_0000;
        avm_be_o         = 4'h0;
        fetch_wait_req_o = 1'b1;
        upd_wait_req_o   = 1'b1;
        case (state_q)
            ST_GRANT_RD: begin
                avm_rd_o         = 1'b1;
                avm_addr_o       = fetch_addr_i;
                avm_be_o         = 4'hF;
                fetch_wait_req_o = avm_wait_req_i;
            end
            ST_GRANT_WR: begin
                avm_wr_o       = 1'b1;
                avm_addr_o     = upd_addr_i;
                avm_wdata_o    = upd_data_i;
                avm_be_o       = upd_be_i;
                upd_wait_req_o = avm_wait_req_i;
            end
            default: begin
                avm_rd_o = 1'b0;
                avm_wr_o = 1'b0;
            end
        endcase
    end

    // The slave returns reads in issue order, so responses need no tagging.
    assign fetch_rd_data_o  = avm_rdata_i;
    assign fetch_rd_valid_o = avm_rdvalid_i;

endmodule

// File: tb/tb_dma_desc_master_arbiter.sv
module tb_dma_desc_master_arbiter;
    import dma_desc_master_arbiter_pkg::*;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_rd_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_wait_req_o;
    logic [31:0] fetch_rd_data_o;
    logic        fetch_rd_valid_o;
    logic        upd_wr_i;
    logic [31:0] upd_addr_i;
    logic [31:0] upd_data_i;
    logic [3:0]  upd_be_i;
    logic        upd_wait_req_o;
    logic        avm_rd_o;
    logic        avm_wr_o;
    logic [31:0] avm_addr_o;
    logic [31:0] avm_wdata_o;
    logic [3:0]  avm_be_o;
    logic        avm_wait_req_i;
    logic [31:0] avm_rdata_i;
    logic        avm_rdvalid_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dma_desc_master_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_rd_i       (fetch_rd_i),
        .fetch_addr_i     (fetch_addr_i),
        .fetch_wait_req_o (fetch_wait_req_o),
        .fetch_rd_data_o  (fetch_rd_data_o),
        .fetch_rd_valid_o (fetch_rd_valid_o),
        .upd_wr_i         (upd_wr_i),
        .upd_addr_i       (upd_addr_i),
        .upd_data_i       (upd_data_i),
        .upd_be_i         (upd_be_i),
        .upd_wait_req_o   (upd_wait_req_o),
        .avm_rd_o         (avm_rd_o),
        .avm_wr_o         (avm_wr_o),
        .avm_addr_o       (avm_addr_o),
        .avm_wdata_o      (avm_wdata_o),
        .avm_be_o         (avm_be_o),
        .avm_wait_req_i   (avm_wait_req_i),
        .avm_rdata_i      (avm_rdata_i),
        .avm_rdvalid_i    (avm_rdvalid_i)
    );

    task automatic drive_idle();
        fetch_rd_i = 1'b0; fetch_addr_i = 32'h0; upd_wr_i = 1'b0; upd_addr_i = 32'h0;
        upd_data_i = 32'h0; upd_be_i = 4'h0; avm_wait_req_i = 1'b0;
        avm_rdata_i = 32'h0; avm_rdvalid_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        fetch_rd_i = 1'b1; upd_wr_i = 1'b1;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        sample();
        checks++; if (avm_rd_o !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", avm_rd_o); end
        checks++; if (avm_wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", avm_wr_o); end
        checks++; if (fetch_wait_req_o !== 1'b1) begin errors++; $display("FAIL reset_fetch_wait: got %b want 1", fetch_wait_req_o); end
        checks++; if (upd_wait_req_o !== 1'b1) begin errors++; $display("FAIL reset_upd_wait: got %b want 1", upd_wait_req_o); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        checks++; if (dut.outstanding_q !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.outstanding_q); end
        reset = 1'b0;
        drive_idle();
    endtask

    task automatic test_fetch_basic();
        int rd_cycles;
        do_reset();
        fetch_rd_i = 1'b1; fetch_addr_i = 32'h0000_1000; avm_wait_req_i = 1'b1;
        sample();
        checks++; if (avm_rd_o !== 1'b0) begin errors++; $display("FAIL fetch_idle_rd: got %b want 0", avm_rd_o); end
        rd_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            avm_wait_req_i = (i < 2);
            sample();
            if (avm_rd_o === 1'b1) rd_cycles++;
            checks++;
            if (avm_addr_o !== 32'h0000_1000 || avm_be_o !== 4'hF || avm_wr_o !== 1'b0 ||
                fetch_wait_req_o !== logic'(i < 2) || upd_wait_req_o !== 1'b1) begin
                errors++;
                $display("FAIL fetch_grant_c%0d: got addr=%h be=%h wr=%b fw=%b uw=%b want addr=00001000 be=f wr=0 fw=%b uw=1",
                         i, avm_addr_o, avm_be_o, avm_wr_o, fetch_wait_req_o, upd_wait_req_o, (i < 2));
            end
        end
        next_cycle();
        fetch_rd_i = 1'b0; avm_wait_req_i = 1'b0;
        avm_rdvalid_i = 1'b1; avm_rdata_i = 32'hDEAD_BEEF;
        sample();
        checks++; if (rd_cycles != 3) begin errors++; $display("FAIL fetch_rd_cycles: got %0d want 3", rd_cycles); end
        checks++; if (avm_rd_o !== 1'b0) begin errors++; $display("FAIL fetch_after_rd: got %b want 0", avm_rd_o); end
        checks++; if (dut.outstanding_q !== 4'd1) begin errors++; $display("FAIL fetch_count1: got %0d want 1", dut.outstanding_q); end
        checks++; if (fetch_rd_valid_o !== 1'b1 || fetch_rd_data_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL fetch_rsp: got v=%b d=%h want v=1 d=deadbeef", fetch_rd_valid_o, fetch_rd_data_o); end
        next_cycle();
        avm_rdvalid_i = 1'b0;
        sample();
        checks++; if (dut.outstanding_q !== 4'd0) begin errors++; $display("FAIL fetch_count0: got %0d want 0", dut.outstanding_q); end
    endtask

    task automatic test_alternation();
        int exp_owner [6] = '{0, 1, 0, 2, 0, 1};
        do_reset();
        fetch_rd_i = 1'b1; fetch_addr_i = 32'h0000_2000;
        upd_wr_i = 1'b1; upd_addr_i = 32'h0000_101C; upd_be_i = 4'b1100; upd_data_i = 32'h0000_00A5;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            if (i == 4) upd_wr_i = 1'b0;
            sample();
            checks++;
            if (avm_rd_o !== logic'(exp_owner[i] == 1) || avm_wr_o !== logic'(exp_owner[i] == 2)) begin
                errors++; $display("FAIL alt_c%0d: got rd=%b wr=%b want owner %0d", i, avm_rd_o, avm_wr_o, exp_owner[i]);
            end
            if (exp_owner[i] == 2) begin
                checks++;
                if (avm_addr_o !== 32'h0000_101C || avm_be_o !== 4'b1100 || avm_wdata_o !== 32'h0000_00A5 ||
                    upd_wait_req_o !== 1'b0 || fetch_wait_req_o !== 1'b1) begin
                    errors++; $display("FAIL alt_wr_payload: got a=%h be=%h d=%h uw=%b fw=%b want a=0000101c be=c d=000000a5 uw=0 fw=1",
                                       avm_addr_o, avm_be_o, avm_wdata_o, upd_wait_req_o, fetch_wait_req_o);
                end
            end
        end
        fetch_rd_i = 1'b0;
    endtask

    task automatic test_max_outstanding();
        do_reset();
        fetch_rd_i = 1'b1; fetch_addr_i = 32'h0000_3000;
        for (int i = 0; i < 8; i++) next_cycle();
        upd_wr_i = 1'b1; upd_addr_i = 32'h0000_1040; upd_data_i = 32'h0000_0055; upd_be_i = 4'hF;
        sample();
        checks++; if (dut.outstanding_q !== 4'd4) begin errors++; $display("FAIL max_count4: got %0d want 4", dut.outstanding_q); end
        next_cycle();
        sample();
        checks++; if (avm_wr_o !== 1'b1 || avm_rd_o !== 1'b0 || fetch_wait_req_o !== 1'b1 || upd_wait_req_o !== 1'b0) begin
            errors++; $display("FAIL max_wr_granted: got wr=%b rd=%b fw=%b uw=%b want wr=1 rd=0 fw=1 uw=0",
                               avm_wr_o, avm_rd_o, fetch_wait_req_o, upd_wait_req_o); end
        next_cycle();
        upd_wr_i = 1'b0;
        sample();
        checks++; if (avm_rd_o !== 1'b0) begin errors++; $display("FAIL max_stall_a: got rd=%b want 0", avm_rd_o); end
        next_cycle();
        avm_rdvalid_i = 1'b1; avm_rdata_i = 32'h1111_2222;
        sample();
        checks++; if (avm_rd_o !== 1'b0) begin errors++; $display("FAIL max_stall_b: got rd=%b want 0", avm_rd_o); end
        next_cycle();
        avm_rdvalid_i = 1'b0;
        sample();
        checks++; if (avm_rd_o !== 1'b0 || dut.outstanding_q !== 4'd3) begin
            errors++; $display("FAIL max_release_idle: got rd=%b cnt=%0d want rd=0 cnt=3", avm_rd_o, dut.outstanding_q); end
        next_cycle();
        sample();
        checks++; if (avm_rd_o !== 1'b1 || avm_addr_o !== 32'h0000_3000) begin
            errors++; $display("FAIL max_release_grant: got rd=%b a=%h want rd=1 a=00003000", avm_rd_o, avm_addr_o); end
        fetch_rd_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        fetch_rd_i = 1'b1; fetch_addr_i = 32'h0000_4000;
        for (int i = 0; i < 5; i++) next_cycle();
        avm_rdvalid_i = 1'b1; avm_rdata_i = 32'h0BAD_F00D;
        sample();
        checks++; if (avm_rd_o !== 1'b1 || dut.outstanding_q !== 4'd2) begin
            errors++; $display("FAIL simul_pre: got rd=%b cnt=%0d want rd=1 cnt=2", avm_rd_o, dut.outstanding_q); end
        next_cycle();
        avm_rdvalid_i = 1'b0; fetch_rd_i = 1'b0;
        sample();
        checks++; if (dut.outstanding_q !== 4'd2) begin errors++; $display("FAIL simul_count: got %0d want 2", dut.outstanding_q); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        fetch_rd_i = 1'b1; fetch_addr_i = 32'h0000_5000;
        next_cycle();
        next_cycle();
        fetch_rd_i = 1'b0;
        upd_wr_i = 1'b1; upd_addr_i = 32'h0000_1080; upd_data_i = 32'h0000_0077; upd_be_i = 4'b0011;
        avm_wait_req_i = 1'b1;
        next_cycle();
        sample();
        checks++; if (avm_wr_o !== 1'b1 || upd_wait_req_o !== 1'b1 || dut.outstanding_q !== 4'd1) begin
            errors++; $display("FAIL rstmid_pre: got wr=%b uw=%b cnt=%0d want wr=1 uw=1 cnt=1", avm_wr_o, upd_wait_req_o, dut.outstanding_q); end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        sample();
        checks++; if (avm_wr_o !== 1'b0 || dut.state_q !== ST_IDLE || dut.outstanding_q !== 4'd0) begin
            errors++; $display("FAIL rstmid_post: got wr=%b st=%0d cnt=%0d want wr=0 st=0 cnt=0", avm_wr_o, dut.state_q, dut.outstanding_q); end
        upd_wr_i = 1'b0; avm_wait_req_i = 1'b0;
        avm_rdvalid_i = 1'b1; avm_rdata_i = 32'h5555_AAAA;
        next_cycle();
        avm_rdvalid_i = 1'b0;
        sample();
        checks++; if (dut.outstanding_q !== 4'd0) begin errors++; $display("FAIL rstmid_stale_rsp: got %0d want 0", dut.outstanding_q); end
    endtask

    task automatic test_spurious_rdvalid();
        do_reset();
        avm_rdvalid_i = 1'b1; avm_rdata_i = 32'hCAFE_0001;
        sample();
        checks++; if (fetch_rd_valid_o !== 1'b1 || fetch_rd_data_o !== 32'hCAFE_0001) begin
            errors++; $display("FAIL spur_pulse: got v=%b d=%h want v=1 d=cafe0001", fetch_rd_valid_o, fetch_rd_data_o); end
        next_cycle();
        avm_rdvalid_i = 1'b0;
        sample();
        checks++; if (dut.outstanding_q !== 4'd0 || fetch_rd_valid_o !== 1'b0) begin
            errors++; $display("FAIL spur_count: got cnt=%0d v=%b want cnt=0 v=0", dut.outstanding_q, fetch_rd_valid_o); end
    endtask

    // Reference model: who owns the bus (0 none, 1 fetch, 2 update), how many
    // reads are in flight, and whether the update side was served last.
    task automatic test_random();
        int m_owner, m_cnt, new_cnt;
        bit m_last_upd, acc_rd, acc_wr, fe, ue, clr_f, clr_u;
        logic [108:0] exp_v, obs_v;
        int rd_total, wr_total;
        do_reset();
        m_owner = 0; m_cnt = 0; m_last_upd = 1'b1; clr_f = 1'b0; clr_u = 1'b0;
        rd_total = 0; wr_total = 0;
        for (int n = 0; n < 2000; n++) begin
            next_cycle();
            if (clr_f) fetch_rd_i = 1'b0;
            if (clr_u) upd_wr_i = 1'b0;
            if (!fetch_rd_i && $urandom_range(0, 2) == 0) begin
                fetch_rd_i = 1'b1; fetch_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!upd_wr_i && $urandom_range(0, 3) == 0) begin
                upd_wr_i = 1'b1; upd_addr_i = $urandom & 32'hFFFF_FFFC;
                upd_data_i = $urandom; upd_be_i = 4'($urandom_range(0, 15));
            end
            avm_wait_req_i = ($urandom_range(0, 3) == 0);
            avm_rdvalid_i  = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            avm_rdata_i    = $urandom;
            sample();
            exp_v = {logic'(m_owner == 1), logic'(m_owner == 2),
                     (m_owner == 1) ? fetch_addr_i : (m_owner == 2) ? upd_addr_i : 32'h0,
                     (m_owner == 2) ? upd_data_i : 32'h0,
                     (m_owner == 1) ? 4'hF : (m_owner == 2) ? upd_be_i : 4'h0,
                     (m_owner == 1) ? avm_wait_req_i : 1'b1,
                     (m_owner == 2) ? avm_wait_req_i : 1'b1,
                     avm_rdvalid_i, avm_rdata_i, 4'(m_cnt)};
            obs_v = {avm_rd_o, avm_wr_o,
                     (m_owner != 0) ? avm_addr_o : 32'h0,
                     (m_owner == 2) ? avm_wdata_o : 32'h0,
                     (m_owner != 0) ? avm_be_o : 4'h0,
                     fetch_wait_req_o, upd_wait_req_o,
                     fetch_rd_valid_o, fetch_rd_data_o, dut.outstanding_q};
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL random_c%0d: got %h want %h", n, obs_v, exp_v);
            end
            acc_rd = (m_owner == 1) && !avm_wait_req_i;
            acc_wr = (m_owner == 2) && !avm_wait_req_i;
            new_cnt = m_cnt + (acc_rd ? 1 : 0) - ((avm_rdvalid_i && m_cnt > 0) ? 1 : 0);
            if (m_owner != 0) begin
                if (!avm_wait_req_i) begin
                    m_last_upd = (m_owner == 2);
                    m_owner = 0;
                end
            end else begin
                fe = fetch_rd_i && (m_cnt < MAX);
                ue = upd_wr_i;
                if (fe && ue) m_owner = m_last_upd ? 1 : 2;
                else if (fe) m_owner = 1;
                else if (ue) m_owner = 2;
                else m_owner = 0;
            end
            m_cnt = new_cnt;
            clr_f = acc_rd; clr_u = acc_wr;
            if (acc_rd) rd_total++;
            if (acc_wr) wr_total++;
        end
        checks++;
        if (rd_total == 0 || wr_total == 0) begin
            errors++; $display("FAIL random_coverage: got reads=%0d writes=%0d want both nonzero", rd_total, wr_total);
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_fetch_basic();
        test_alternation();
        test_max_outstanding();
        test_simultaneous();
        test_reset_mid_write();
        test_spurious_rdvalid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
